// File: rtl/alu_legv8_pkg.sv
// alu_legv8_pkg: opcodes, status bit indices, FSM states and status packing shared by the LEGv8 ALU.
package alu_legv8_pkg;
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SHL = 3'd4;
  localparam logic [2:0] OP_SHR = 3'd5;
  localparam logic [2:0] OP_RSV = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;
  localparam int ST_Z = 0;
  localparam int ST_N = 1;
  localparam int ST_C = 2;
  localparam int ST_V = 3;
  typedef enum logic {IDLE, MUL} state_t;
  function automatic logic [3:0] pack_status(input logic v, input logic c, input logic n, input logic z);
    logic [3:0] s;
    s = '0;
    s[ST_V] = v;
    s[ST_C] = c;
    s[ST_N] = n;
    s[ST_Z] = z;
    return s;
  endfunction
endpackage

// File: rtl/alu_legv8_mul_iter.sv
// alu_legv8_mul_iter: iterative unsigned shift-add multiplier, WIDTH steps per product.
//   clk, rst_n    : clock, async active-low reset
//   start_i       : load a_i/b_i and begin
//   a_i, b_i      : multiplicand, multiplier (sampled on start_i)
//   done_o        : prod_o valid this cycle (last step folded in combinationally)
//   prod_o        : full 2*WIDTH product
module alu_legv8_mul_iter #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d, step;
  // The final partial product is added on the fly so the result is ready
  // after WIDTH-1 registered steps plus the consuming edge.
  always_comb begin
    step     = busy_q & (cnt_q != '0);
    done_o   = busy_q & (cnt_q == CW'(1));
    prod_o   = acc_q + (mplier_q[0] ? mcand_q : '0);
    acc_d    = start_i ? '0 : (step & mplier_q[0]) ? acc_q + mcand_q : acc_q;
    mcand_d  = start_i ? {{WIDTH{1'b0}}, a_i} : step ? mcand_q << 1 : mcand_q;
    mplier_d = start_i ? b_i : step ? mplier_q >> 1 : mplier_q;
    cnt_d    = start_i ? CW'(WIDTH) : step ? cnt_q - CW'(1) : cnt_q;
    busy_d   = start_i | (busy_q & ~done_o);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end
endmodule

// File: rtl/alu_legv8_seq.sv
// alu_legv8_seq: registered, valid/ready handshaked LEGv8 ALU with iterative multiplier.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : operand beat handshake (A, B, FS, C0 sampled on accept)
//   FS                  : [0] invert A, [1] invert B, [4:2] opcode
//   out_valid/out_ready : result handshake for F and status {V,C,N,Z}
//   ALU_ASR_EN          : when defined, opcode 110 is arithmetic shift right of A
module alu_legv8_seq
  import alu_legv8_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       FS,
  input  logic             C0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic [3:0]       status
);
  localparam int SW = $clog2(WIDTH);
  state_t             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   f_q, f_d, as_w, bs_w, res, rsv_w;
  logic [3:0]         st_q, st_d, flags, mul_flags;
  logic [WIDTH:0]     sum;
  logic [SW-1:0]      sh;
  logic [2:0]         op;
  logic               accept, mul_start, mul_done;
  logic [2*WIDTH-1:0] prod;
  assign in_ready  = (state_q == IDLE) & (~out_valid_q | out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign F         = f_q;
  assign status    = st_q;
`ifdef ALU_ASR_EN
  assign rsv_w = $signed(A) >>> sh;
`else
  assign rsv_w = '0;
`endif
  always_comb begin
    op    = FS[4:2];
    as_w  = FS[0] ? ~A : A;
    bs_w  = FS[1] ? ~B : B;
    sh    = B[SW-1:0];
    sum   = {1'b0, as_w} + {1'b0, bs_w} + {{WIDTH{1'b0}}, C0};
    res   = op == OP_AND ? as_w & bs_w :
            op == OP_OR  ? as_w | bs_w :
            op == OP_XOR ? as_w ^ bs_w :
            op == OP_ADD ? sum[WIDTH-1:0] :
            op == OP_SHL ? A << sh :
            op == OP_SHR ? A >> sh :
            op == OP_RSV ? rsv_w : '0;
    flags = pack_status((op == OP_ADD) & ~(as_w[WIDTH-1] ^ bs_w[WIDTH-1]) & (res[WIDTH-1] ^ as_w[WIDTH-1]),
                        (op == OP_ADD) & sum[WIDTH], res[WIDTH-1], res == '0);
    mul_flags = pack_status(|prod[2*WIDTH-1:WIDTH], 1'b0, prod[WIDTH-1], prod[WIDTH-1:0] == '0);
  end
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q & ~out_ready;
    f_d         = f_q;
    st_d        = st_q;
    mul_start   = 1'b0;
    if (state_q == IDLE) begin
      if (accept && op == OP_MUL) begin
        mul_start   = 1'b1;
        state_d     = MUL;
        out_valid_d = 1'b0;
      end else if (accept) begin
        f_d         = res;
        st_d        = flags;
        out_valid_d = 1'b1;
      end
    end else if (mul_done) begin
      f_d         = prod[WIDTH-1:0];
      st_d        = mul_flags;
      out_valid_d = 1'b1;
      state_d     = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      f_q         <= '0;
      st_q        <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      f_q         <= f_d;
      st_q        <= st_d;
    end
  end
  alu_legv8_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (mul_start),
    .a_i     (as_w),
    .b_i     (bs_w),
    .done_o  (mul_done),
    .prod_o  (prod)
  );
endmodule

// File: tb/tb_alu_legv8_seq.sv
// tb_alu_legv8_seq: self-checking bench for alu_legv8_seq against an arithmetic reference model.
module tb_alu_legv8_seq;
  localparam int W = 64;
  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, C0 = 1'b0, out_ready = 1'b0;
  logic         in_ready, out_valid;
  logic [W-1:0] A = '0, B = '0, F;
  logic [4:0]   FS = '0;
  logic [3:0]   status;
  int           n_vec = 0, n_bad = 0;

  alu_legv8_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .FS(FS), .C0(C0),
    .out_valid(out_valid), .out_ready(out_ready), .F(F), .status(status)
  );

  always #5 clk = ~clk;

  // Returns {V,C,N,Z,F} computed directly from the operation definitions.
  function automatic logic [67:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic [4:0] fs, input logic c0);
    logic [63:0]  as_, bs_, f, ones;
    logic [64:0]  s;
    logic [127:0] p;
    logic         v, c;
    int           sh;
    as_ = fs[0] ? ~a : a;
    bs_ = fs[1] ? ~b : b;
    sh = int'(b[5:0]);
    ones = '1;
    v = 1'b0;
    c = 1'b0;
    case (fs[4:2])
      3'd0: f = as_ & bs_;
      3'd1: f = as_ | bs_;
      3'd2: f = as_ ^ bs_;
      3'd3: begin
        s = 65'(as_) + 65'(bs_) + 65'(c0);
        f = s[63:0];
        c = s[64];
        v = (as_[63] == bs_[63]) && (f[63] != as_[63]);
      end
      3'd4: f = a << sh;
      3'd5: f = a >> sh;
`ifdef ALU_ASR_EN
      3'd6: f = (a >> sh) | (a[63] ? ~(ones >> sh) : 64'd0);
`else
      3'd6: f = 64'd0;
`endif
      default: begin
        p = 128'(as_) * 128'(bs_);
        f = p[63:0];
        v = p[127:64] != 0;
      end
    endcase
    return {v, c, f[63], f == 64'd0, f};
  endfunction

  task automatic scramble();
    A = {$urandom, $urandom};
    B = {$urandom, $urandom};
    FS = 5'($urandom);
    C0 = 1'($urandom);
  endtask

  task automatic idle_sync();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Presents one beat, scrambles operands after accept, waits (bounded) for the result.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [4:0] fs,
                        input logic c0, output logic [63:0] f, output logic [3:0] st,
                        output int lat, output bit ok);
    ok = 1'b0;
    lat = 0;
    f = '0;
    st = '0;
    @(negedge clk);
    A = a; B = b; FS = fs; C0 = c0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && !in_ready; i++) @(negedge clk);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    scramble();
    for (int i = 1; i <= 200; i++) begin
      if (out_valid) begin
        f = F;
        st = status;
        lat = i;
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if (out_valid !== 1'b0 || F !== '0 || status !== 4'b0) begin
      n_bad++;
      $display("FAIL reset: got ov=%b F=%h st=%b, want ov=0 F=0 st=0000", out_valid, F, status);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [63:0] va[8], vb[8], ef[8], f;
    logic [4:0]  vfs[8];
    logic        vc0[8];
    logic [3:0]  est[8], st;
    int          elat[8], lat;
    bit          ok;
    va[0] = '1;                     vb[0] = 64'd1;  vfs[0] = 5'b01100; vc0[0] = 0; ef[0] = 64'd0;  est[0] = 4'b0101; elat[0] = 1;
    va[1] = 64'h7FFF_FFFF_FFFF_FFFF; vb[1] = va[1];  vfs[1] = 5'b01100; vc0[1] = 0; ef[1] = 64'hFFFF_FFFF_FFFF_FFFE; est[1] = 4'b1010; elat[1] = 1;
    va[2] = 64'd5;                  vb[2] = 64'd7;  vfs[2] = 5'b01110; vc0[2] = 1; ef[2] = 64'hFFFF_FFFF_FFFF_FFFE; est[2] = 4'b0010; elat[2] = 1;
    va[3] = 64'h8000_0000_0000_0000; vb[3] = 64'd63; vfs[3] = 5'b10100; vc0[3] = 0; ef[3] = 64'd1;  est[3] = 4'b0000; elat[3] = 1;
    va[4] = va[3];                  vb[4] = 64'd63; vfs[4] = 5'b11000; vc0[4] = 0;
`ifdef ALU_ASR_EN
    ef[4] = '1; est[4] = 4'b0010;
`else
    ef[4] = '0; est[4] = 4'b0001;
`endif
    elat[4] = 1;
    va[5] = 64'd3;                  vb[5] = 64'd5;  vfs[5] = 5'b11100; vc0[5] = 0; ef[5] = 64'd15; est[5] = 4'b0000; elat[5] = 65;
    va[6] = 64'h8000_0000_0000_0000; vb[6] = 64'd4;  vfs[6] = 5'b11100; vc0[6] = 0; ef[6] = 64'd0;  est[6] = 4'b1001; elat[6] = 65;
    va[7] = 64'hF0F0;               vb[7] = 64'd4;  vfs[7] = 5'b10000; vc0[7] = 0; ef[7] = 64'hF0F00; est[7] = 4'b0000; elat[7] = 1;
    for (int i = 0; i < 8; i++) begin
      run_op(va[i], vb[i], vfs[i], vc0[i], f, st, lat, ok);
      n_vec++;
      if (!ok || f !== ef[i] || st !== est[i] || lat != elat[i]) begin
        n_bad++;
        $display("FAIL directed[%0d]: got ok=%0d F=%h st=%b lat=%0d, want F=%h st=%b lat=%0d",
                 i, ok, f, st, lat, ef[i], est[i], elat[i]);
      end
    end
  endtask

  task automatic test_mul_latency();
    logic [63:0] a, b;
    logic [67:0] e;
    int          busy_low;
    idle_sync();
    a = {$urandom, $urandom};
    b = {32'd0, $urandom};
    e = model(a, b, 5'b11100, 1'b0);
    A = a; B = b; FS = 5'b11100; C0 = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    scramble();
    busy_low = 0;
    for (int i = 1; i <= 64; i++) begin
      if (in_ready === 1'b0 && out_valid === 1'b0) busy_low++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_vec++;
    if (busy_low != 64) begin
      n_bad++;
      $display("FAIL mul_busy: got %0d cycles busy, want 64", busy_low);
    end
    n_vec++;
    if (out_valid !== 1'b1 || F !== e[63:0] || status !== e[67:64]) begin
      n_bad++;
      $display("FAIL mul_cycle65: got ov=%b F=%h st=%b, want ov=1 F=%h st=%b", out_valid, F, status, e[63:0], e[67:64]);
    end
  endtask

  task automatic test_random();
    logic [63:0] a, b, f;
    logic [4:0]  fs;
    logic        c0;
    logic [67:0] e;
    logic [3:0]  st;
    int          lat;
    bit          ok;
    for (int k = 0; k < 30; k++) begin
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 63));
      fs = {3'($urandom_range(0, 7)), 2'($urandom)};
      if (k % 2 == 0 && fs[4:2] == 3'd7) fs[4:2] = 3'd3;
      c0 = 1'($urandom);
      e = model(a, b, fs, c0);
      run_op(a, b, fs, c0, f, st, lat, ok);
      n_vec++;
      if (!ok || f !== e[63:0] || st !== e[67:64] || lat != (fs[4:2] == 3'd7 ? 65 : 1)) begin
        n_bad++;
        $display("FAIL random[%0d] fs=%b a=%h b=%h c0=%b: got ok=%0d F=%h st=%b lat=%0d, want F=%h st=%b",
                 k, fs, a, b, c0, ok, f, st, lat, e[63:0], e[67:64]);
      end
    end
  endtask

  task automatic test_stall();
    logic [67:0] e1, e2;
    logic [63:0] a2, b2;
    idle_sync();
    A = {$urandom, $urandom}; B = {$urandom, $urandom}; FS = 5'b00100; C0 = 1'b0;
    e1 = model(A, B, FS, C0);
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
    A = a2; B = b2; FS = 5'b01000; C0 = 1'b0;
    e2 = model(a2, b2, 5'b01000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || F !== e1[63:0] || status !== e1[67:64]) begin
        n_bad++;
        $display("FAIL stall[%0d]: got ov=%b rdy=%b F=%h st=%b, want ov=1 rdy=0 F=%h st=%b",
                 i, out_valid, in_ready, F, status, e1[63:0], e1[67:64]);
      end
      if (i < 3) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || F !== e2[63:0] || status !== e2[67:64]) begin
      n_bad++;
      $display("FAIL stall_release: got ov=%b F=%h st=%b, want ov=1 F=%h st=%b",
               out_valid, F, status, e2[63:0], e2[67:64]);
    end
  endtask

  task automatic test_back_to_back();
    logic [67:0] e[$];
    logic [67:0] x, em;
    logic [4:0]  fs;
    bit          seen;
    idle_sync();
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin
        x = e.pop_front();
        n_vec++;
        if (out_valid !== 1'b1 || F !== x[63:0] || status !== x[67:64]) begin
          n_bad++;
          $display("FAIL b2b[%0d]: got ov=%b F=%h st=%b, want ov=1 F=%h st=%b",
                   k, out_valid, F, status, x[63:0], x[67:64]);
        end
      end
      fs = (k == 8) ? {3'd7, 2'($urandom)} : {3'($urandom_range(0, 6)), 2'($urandom)};
      A = {$urandom, $urandom}; B = {$urandom, $urandom}; FS = fs; C0 = 1'($urandom);
      e.push_back(model(A, B, FS, C0));
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    scramble();
    em = e.pop_front();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_mul_drop: got ov=%b want 0", out_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    n_vec++;
    if (!seen || F !== em[63:0] || status !== em[67:64]) begin
      n_bad++;
      $display("FAIL b2b_mul: got seen=%0d F=%h st=%b, want F=%h st=%b", seen, F, status, em[63:0], em[67:64]);
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [63:0] f;
    logic [3:0]  st;
    logic [67:0] e;
    int          lat;
    bit          ok;
    run_op(64'h1, 64'h2, 5'b00100, 1'b0, f, st, lat, ok);
    idle_sync();
    A = {$urandom, $urandom}; B = {$urandom, $urandom}; FS = 5'b11100; C0 = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || F !== '0 || status !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_mid_mul: got ov=%b F=%h st=%b, want ov=0 F=0 st=0000", out_valid, F, status);
    end
    @(negedge clk);
    rst_n = 1'b1;
    e = model(64'd100, 64'd58, 5'b01110, 1'b1);
    run_op(64'd100, 64'd58, 5'b01110, 1'b1, f, st, lat, ok);
    n_vec++;
    if (!ok || f !== e[63:0] || st !== e[67:64] || lat != 1) begin
      n_bad++;
      $display("FAIL after_reset: got ok=%0d F=%h st=%b lat=%0d, want F=%h st=%b lat=1",
               ok, f, st, lat, e[63:0], e[67:64]);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul_latency();
    test_random();
    test_stall();
    test_back_to_back();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
